// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB register interface: register offsets,
// status/IER bit positions, the access FSM state type and a counter-width helper.
package uart_apb_pkg;

  // Byte offsets of the registers, compared against {PADDR[4:2], 2'b00}
  localparam logic [4:0] OFF_DATA   = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
  localparam logic [4:0] OFF_CTRL   = 5'h08;
  localparam logic [4:0] OFF_BAUD   = 5'h0C;
  localparam logic [4:0] OFF_IER    = 5'h10;

  // STATUS bit positions
  localparam int ST_TX_FULL  = 0;
  localparam int ST_RX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_OVERRUN  = 3;

  // CTRL bit positions
  localparam int CTRL_SOFT_RST = 0;

  // IER bit positions
  localparam int IER_RX_NOT_EMPTY = 0;
  localparam int IER_TX_NOT_FULL  = 1;
  localparam int IER_OVERRUN      = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    STALL,
    RESP
  } state_t;

  // Counter width able to hold max_val; always at least one bit.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 2);
  endfunction

endpackage

// File: rtl/uart_apb_hold_timer.sv
// Loadable saturating down-counter. done is high whenever the count is zero;
// the count stops at zero instead of wrapping.
module uart_apb_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  // Load has priority over counting; counting halts at zero.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/uart_apb_regif.sv
// APB3 slave register interface for a UART: DATA (TX push / RX pop), STATUS
// (live FIFO flags plus sticky W1C overrun), CTRL (counted soft reset) and BAUD.
// FIFO-dependent DATA accesses wait in STALL and error out after TIMEOUT cycles.
// Optional macro UART_APB_IRQ_EN adds the IER register at 0x10 and the irq output.
module uart_apb_regif
  import uart_apb_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int DIV_W    = 16,
  parameter int TIMEOUT  = 64,
  parameter int RST_HOLD = 16
) (
  input  logic              pclk,
  input  logic              PRESET,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] tx_fifo_dataIn,
  output logic              tx_fifo_writeEn,
  input  logic              tx_fifo_Full,
  input  logic [DATA_W-1:0] rx_fifo_dataOut,
  output logic              rx_fifo_readEn,
  input  logic              rx_fifo_Empty,
  input  logic              rx_fifo_Full,
  output logic [DIV_W-1:0]  baud_div,
`ifdef UART_APB_IRQ_EN
  output logic              irq,
`endif
  output logic              uart_reset
);

  localparam int TO_W       = cnt_width(TIMEOUT);
  localparam int HOLD_W     = cnt_width(RST_HOLD);
  // Loading TIMEOUT-1 makes done rise in the TIMEOUT-th stall cycle.
  localparam int STALL_LOAD = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_t     state;
  logic [4:0] addr_off;
  logic       mapped;
  logic       need_stall;
  logic       in_xfer;
  logic       do_act;
  logic       timed_out;
  logic       err_now;
  logic       stall_load;
  logic       stall_done;
  logic       hold_done;
  logic       soft_rst;
  logic       ovr_clear;
  logic       overrun;
  logic [31:0] rd_word;
`ifdef UART_APB_IRQ_EN
  logic [2:0] ier;
`endif

  // Only PADDR[4:2] take part in decoding; PWDATA is used piecewise.
  logic unused_bits;
  assign unused_bits = ^{PADDR, PWDATA};

  assign addr_off   = {PADDR[4:2], 2'b00};
  assign uart_reset = !hold_done;

  // A DATA access waits while its FIFO cannot serve it or the UART core is in reset.
  assign need_stall = (addr_off == OFF_DATA) &&
                      ((PWRITE && tx_fifo_Full) || (!PWRITE && rx_fifo_Empty) || uart_reset);
  assign in_xfer    = PSEL && (state == ACCESS || state == STALL);
  assign do_act     = in_xfer && mapped && !need_stall;
  assign timed_out  = (TIMEOUT != 0) && PSEL && (state == STALL) && need_stall && stall_done;
  assign err_now    = (PSEL && state == ACCESS && !mapped) || timed_out;
  assign stall_load = PSEL && (state == ACCESS) && mapped && need_stall;
  assign soft_rst   = do_act && PWRITE && (addr_off == OFF_CTRL) && PWDATA[CTRL_SOFT_RST];
  assign ovr_clear  = soft_rst ||
                      (do_act && PWRITE && (addr_off == OFF_STATUS) && PWDATA[ST_OVERRUN]);

  // Address decode: which offsets exist in this build.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mapped = 1'b0;
    case (addr_off)
      OFF_DATA, OFF_STATUS, OFF_CTRL, OFF_BAUD: mapped = 1'b1;
`ifdef UART_APB_IRQ_EN
      OFF_IER: mapped = 1'b1;
`endif
      default: mapped = 1'b0;
    endcase
  end

  // Read data mux; CTRL and unmapped offsets read as zero.
  always_comb begin
    rd_word = '0;
    case (addr_off)
      OFF_DATA: rd_word = 32'(rx_fifo_dataOut);
      OFF_STATUS: begin
        rd_word[ST_TX_FULL]  = tx_fifo_Full;
        rd_word[ST_RX_EMPTY] = rx_fifo_Empty;
        rd_word[ST_RX_FULL]  = rx_fifo_Full;
        rd_word[ST_OVERRUN]  = overrun;
      end
      OFF_BAUD: rd_word = 32'(baud_div);
`ifdef UART_APB_IRQ_EN
      OFF_IER: rd_word = 32'(ier);
`endif
      default: rd_word = '0;
    endcase
  end

  // Access FSM with registered bus response, FIFO strobes and register updates.
  always_ff @(posedge pclk) begin
    if (PRESET) begin
      state           <= IDLE;
      PRDATA          <= '0;
      PREADY          <= 1'b0;
      PSLVERR         <= 1'b0;
      tx_fifo_writeEn <= 1'b0;
      rx_fifo_readEn  <= 1'b0;
      tx_fifo_dataIn  <= '0;
      baud_div        <= DIV_W'(1);
      overrun         <= 1'b0;
`ifdef UART_APB_IRQ_EN
      ier             <= '0;
`endif
    end else begin
      tx_fifo_writeEn <= 1'b0;
      rx_fifo_readEn  <= 1'b0;
      PREADY          <= 1'b0;
      PSLVERR         <= 1'b0;
      // A new overrun event wins over a simultaneous clear.
      if (rx_fifo_Full) begin
        overrun <= 1'b1;
      end else if (ovr_clear) begin
        overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) state <= ACCESS;
        end
        ACCESS, STALL: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (err_now) begin
            PREADY  <= 1'b1;
            PSLVERR <= 1'b1;
            PRDATA  <= '0;
            state   <= RESP;
          end else if (do_act) begin
            PREADY <= 1'b1;
            state  <= RESP;
            if (PWRITE) begin
              PRDATA <= '0;
              case (addr_off)
                OFF_DATA: begin
                  tx_fifo_writeEn <= 1'b1;
                  tx_fifo_dataIn  <= PWDATA[DATA_W-1:0];
                end
                OFF_BAUD: baud_div <= PWDATA[DIV_W-1:0];
`ifdef UART_APB_IRQ_EN
                OFF_IER: ier <= PWDATA[2:0];
`endif
                default: ;
              endcase
            end else begin
              PRDATA <= rd_word;
              if (addr_off == OFF_DATA) rx_fifo_readEn <= 1'b1;
            end
          end else begin
            state <= STALL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_APB_IRQ_EN
  // Interrupt: OR of enabled conditions, registered.
  always_ff @(posedge pclk) begin
    if (PRESET) begin
      irq <= 1'b0;
    end else begin
      irq <= |(ier & {overrun, !tx_fifo_Full, !rx_fifo_Empty});
    end
  end
`endif

  // Stall timeout: loaded on entering STALL, counts each stall cycle.
  uart_apb_hold_timer #(.W(TO_W)) u_stall_timer (
    .clk      (pclk),
    .rst      (PRESET),
    .load     (stall_load),
    .load_val (TO_W'(STALL_LOAD)),
    .en       (state == STALL),
    .done     (stall_done)
  );

  // Soft-reset hold: uart_reset is high while this counter is non-zero.
  uart_apb_hold_timer #(.W(HOLD_W)) u_hold_timer (
    .clk      (pclk),
    .rst      (PRESET),
    .load     (soft_rst),
    .load_val (HOLD_W'(RST_HOLD)),
    .en       (1'b1),
    .done     (hold_done)
  );

endmodule

// File: tb/tb_uart_apb_regif.sv
// Scoreboard bench for uart_apb_regif: directed APB transfers push their
// expected response; a negedge monitor pops and compares on every PREADY.
module tb_uart_apb_regif;
  import uart_apb_pkg::*;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 8;
  localparam int DIV_W    = 16;
  localparam int TIMEOUT  = 64;
  localparam int RST_HOLD = 16;

  logic              pclk;
  logic              PRESET;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic              PSEL, PENABLE, PWRITE;
  logic [31:0]       PRDATA;
  logic              PREADY, PSLVERR;
  logic [DATA_W-1:0] tx_fifo_dataIn;
  logic              tx_fifo_writeEn, tx_fifo_Full;
  logic [DATA_W-1:0] rx_fifo_dataOut;
  logic              rx_fifo_readEn, rx_fifo_Empty, rx_fifo_Full;
  logic [DIV_W-1:0]  baud_div;
  logic              uart_reset;
`ifdef UART_APB_IRQ_EN
  logic              irq;
`endif

  uart_apb_regif #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W),
    .TIMEOUT(TIMEOUT), .RST_HOLD(RST_HOLD)
  ) dut (
    .pclk(pclk), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_fifo_dataIn(tx_fifo_dataIn), .tx_fifo_writeEn(tx_fifo_writeEn),
    .tx_fifo_Full(tx_fifo_Full), .rx_fifo_dataOut(rx_fifo_dataOut),
    .rx_fifo_readEn(rx_fifo_readEn), .rx_fifo_Empty(rx_fifo_Empty),
    .rx_fifo_Full(rx_fifo_Full), .baud_div(baud_div),
`ifdef UART_APB_IRQ_EN
    .irq(irq),
`endif
    .uart_reset(uart_reset)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    string             name;
    logic [31:0]       prdata;
    logic              slverr;
    int                lat;    // cycles from setup cycle to PREADY cycle
    int                n_tx;
    int                n_rx;
    logic [DATA_W-1:0] txd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   tx_cnt = 0;
  int   rx_cnt = 0;
  int   rst_run = 0;
  int   last_hold = 0;
  logic [DATA_W-1:0] tx_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string name, input logic [31:0] prdata, input logic slverr,
                              input int lat, input int n_tx, input int n_rx,
                              input logic [DATA_W-1:0] txd);
    exp_t e;
    e.name = name; e.prdata = prdata; e.slverr = slverr; e.lat = lat;
    e.n_tx = n_tx; e.n_rx = n_rx; e.txd = txd;
    return e;
  endfunction

  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: strobe accounting, hold-length measurement, scoreboard compare on PREADY.
  always @(negedge pclk) begin
    if (!PRESET) begin
      if (tx_fifo_writeEn) begin
        tx_cnt++;
        tx_seen = tx_fifo_dataIn;
      end
      if (rx_fifo_readEn) rx_cnt++;
      if (tx_fifo_writeEn && rx_fifo_readEn) begin
        checks++;
        failures++;
        $display("FAIL both_strobes actual=1 expected=0");
      end
      if (uart_reset) rst_run++;
      else if (rst_run != 0) begin
        last_hold = rst_run;
        rst_run = 0;
      end
      if (PREADY) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pready actual=1 expected=0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_prdata"}, PRDATA, e.prdata);
          check({e.name, "_pslverr"}, 32'(PSLVERR), 32'(e.slverr));
          check({e.name, "_latency"}, 32'(cyc - start_cyc), 32'(e.lat));
          check({e.name, "_tx_pulses"}, 32'(tx_cnt), 32'(e.n_tx));
          check({e.name, "_rx_pulses"}, 32'(rx_cnt), 32'(e.n_rx));
          if (e.n_tx != 0) check({e.name, "_tx_data"}, 32'(tx_seen), 32'(e.txd));
          tx_cnt = 0;
          rx_cnt = 0;
        end
      end
    end
  end

  // One APB transfer; the expected response goes to the scoreboard first.
  task automatic apb(input logic wr, input logic [4:0] off, input logic [31:0] wdata, input exp_t e);
    bit done;
    done = 1'b0;
    sb.push_back(e);
    @(posedge pclk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = ADDR_W'(off); PWDATA = wdata;
    start_cyc = cyc;
    @(posedge pclk); #1;
    PENABLE = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk);
      if (PREADY) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check({e.name, "_no_pready"}, 32'(done), 32'd1);
    @(posedge pclk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    tx_fifo_Full = 1'b0; rx_fifo_Empty = 1'b0; rx_fifo_Full = 1'b0; rx_fifo_dataOut = 8'hC3;
    repeat (3) @(posedge pclk);
    #1 PRESET = 1'b0;
    @(negedge pclk);
    check("rst_pready", 32'(PREADY), 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_baud", 32'(baud_div), 32'd1);
    check("rst_uart_reset", 32'(uart_reset), 32'd0);

    // Basic DATA write and read
    apb(1'b1, OFF_DATA, 32'h0000_A55A, mk("wr_data", 32'h0, 1'b0, 2, 1, 0, 8'h5A));
    apb(1'b0, OFF_DATA, 32'h0, mk("rd_data", 32'h0000_00C3, 1'b0, 2, 0, 1, 8'h00));

    // Read from empty RX FIFO times out after 64 stall cycles
    rx_fifo_Empty = 1'b1;
    apb(1'b0, OFF_DATA, 32'h0, mk("rd_timeout", 32'h0, 1'b1, 66, 0, 0, 8'h00));

    // Same read, RX data arrives in stall cycle 10
    fork
      apb(1'b0, OFF_DATA, 32'h0, mk("rd_late", 32'h0000_00C3, 1'b0, 12, 0, 1, 8'h00));
      begin
        repeat (12) @(posedge pclk);
        #1 rx_fifo_Empty = 1'b0;
      end
    join

    // Baud divisor
    apb(1'b1, OFF_BAUD, 32'hABCD_1234, mk("wr_baud", 32'h0, 1'b0, 2, 0, 0, 8'h00));
    apb(1'b0, OFF_BAUD, 32'h0, mk("rd_baud", 32'h0000_1234, 1'b0, 2, 0, 0, 8'h00));
    check("baud_port", 32'(baud_div), 32'h1234);

    // Soft reset, then a DATA write that must wait out the hold
    apb(1'b1, OFF_CTRL, 32'h1, mk("wr_ctrl", 32'h0, 1'b0, 2, 0, 0, 8'h00));
    apb(1'b1, OFF_DATA, 32'h77, mk("wr_in_hold", 32'h0, 1'b0, 15, 1, 0, 8'h77));
    check("hold_len", 32'(last_hold), 32'd16);
    check("baud_kept", 32'(baud_div), 32'h1234);
    apb(1'b0, OFF_CTRL, 32'h0, mk("rd_ctrl", 32'h0, 1'b0, 2, 0, 0, 8'h00));

    // Unmapped offsets
    apb(1'b0, 5'h14, 32'h0, mk("rd_0x14", 32'h0, 1'b1, 2, 0, 0, 8'h00));
    apb(1'b1, 5'h14, 32'hFF, mk("wr_0x14", 32'h0, 1'b1, 2, 0, 0, 8'h00));
`ifndef UART_APB_IRQ_EN
    apb(1'b0, OFF_IER, 32'h0, mk("rd_0x10", 32'h0, 1'b1, 2, 0, 0, 8'h00));
`endif

    // PSEL dropped mid-stall: no PREADY, no pop even after data shows up
    rx_fifo_Empty = 1'b1;
    @(posedge pclk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0;
    @(posedge pclk); #1 PENABLE = 1'b1;
    repeat (4) @(posedge pclk);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge pclk); #1 rx_fifo_Empty = 1'b0;
    repeat (3) @(posedge pclk);
    #1 check("psel_drop_no_pop", 32'(rx_cnt), 32'd0);
    rx_fifo_dataOut = 8'h81;
    apb(1'b0, OFF_DATA, 32'h0, mk("rd_after_drop", 32'h0000_0081, 1'b0, 2, 0, 1, 8'h00));

    // STATUS: overrun sticky, W1C, set wins over clear
    rx_fifo_Full = 1'b1;
    repeat (2) @(posedge pclk);
    apb(1'b0, OFF_STATUS, 32'h0, mk("st_full", 32'h0C, 1'b0, 2, 0, 0, 8'h00));
    apb(1'b1, OFF_STATUS, 32'h8, mk("w1c_while_full", 32'h0, 1'b0, 2, 0, 0, 8'h00));
    apb(1'b0, OFF_STATUS, 32'h0, mk("st_set_wins", 32'h0C, 1'b0, 2, 0, 0, 8'h00));
    rx_fifo_Full = 1'b0;
    apb(1'b0, OFF_STATUS, 32'h0, mk("st_sticky", 32'h08, 1'b0, 2, 0, 0, 8'h00));
    apb(1'b1, OFF_STATUS, 32'h8, mk("w1c", 32'h0, 1'b0, 2, 0, 0, 8'h00));
    apb(1'b0, OFF_STATUS, 32'h0, mk("st_cleared", 32'h00, 1'b0, 2, 0, 0, 8'h00));
    tx_fifo_Full = 1'b1; rx_fifo_Empty = 1'b1;
    apb(1'b0, OFF_STATUS, 32'h0, mk("st_flags", 32'h03, 1'b0, 2, 0, 0, 8'h00));
    tx_fifo_Full = 1'b0; rx_fifo_Empty = 1'b0;

    // Soft reset clears overrun
    @(posedge pclk); #1 rx_fifo_Full = 1'b1;
    @(posedge pclk); #1 rx_fifo_Full = 1'b0;
    apb(1'b1, OFF_CTRL, 32'h1, mk("wr_ctrl2", 32'h0, 1'b0, 2, 0, 0, 8'h00));
    apb(1'b0, OFF_STATUS, 32'h0, mk("st_after_srst", 32'h00, 1'b0, 2, 0, 0, 8'h00));
    apb(1'b0, OFF_BAUD, 32'h0, mk("rd_baud2", 32'h0000_1234, 1'b0, 2, 0, 0, 8'h00));

    // PRESET during a stalled DATA read while uart_reset is still held
    rx_fifo_Empty = 1'b1;
    @(posedge pclk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0;
    @(posedge pclk); #1 PENABLE = 1'b1;
    repeat (2) @(posedge pclk);
    #1 PRESET = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    check("preset_pready", 32'(PREADY), 32'd0);
    check("preset_pslverr", 32'(PSLVERR), 32'd0);
    check("preset_prdata", PRDATA, 32'd0);
    check("preset_strobes", 32'({tx_fifo_writeEn, rx_fifo_readEn}), 32'd0);
    check("preset_uart_reset", 32'(uart_reset), 32'd0);
    check("preset_baud", 32'(baud_div), 32'd1);
    check("preset_no_pop", 32'(rx_cnt), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge pclk); #1 PRESET = 1'b0;
    rx_fifo_Empty = 1'b0;
    tx_cnt = 0; rx_cnt = 0;
    apb(1'b1, OFF_DATA, 32'h3C, mk("wr_after_preset", 32'h0, 1'b0, 2, 1, 0, 8'h3C));

    repeat (3) @(posedge pclk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_apb_regif.md
Name: uart_apb_regif

Overview:
- Parametrised APB3 slave register interface between the APB bus and the UART TX/RX FIFOs and baud generator.
- Replaces delay-based strobes with a clocked access FSM: single-cycle FIFO strobes, registered PREADY/PRDATA, PSLVERR on errors or timeout.
- Adds a status register and a baud-divisor register.
- Adds a counted, self-clearing UART soft reset.

Parameters:
- ADDR_W, 12, PADDR width; only PADDR[4:2] decoded.
- DATA_W, 8, UART character width (5..9); FIFO data width.
- DIV_W, 16, baud divisor width.
- TIMEOUT, 64, max wait cycles on a FIFO stall before PSLVERR; 0 = wait forever.
- RST_HOLD, 16, uart_reset assertion length in pclk cycles (>=1).

Ports:
- pclk  in  1  APB clock, single clock domain.
- PRESET  in  1  synchronous active-high reset.
- PADDR  in  ADDR_W  address.
- PWDATA  in  32  write data.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write.
- PRDATA  out  32  read data, registered.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error, valid only with PREADY.
- tx_fifo_dataIn  out  DATA_W  PWDATA[DATA_W-1:0].
- tx_fifo_writeEn  out  1  one-cycle push.
- tx_fifo_Full  in  1.
- rx_fifo_dataOut  in  DATA_W  first-word-fall-through head.
- rx_fifo_readEn  out  1  one-cycle pop.
- rx_fifo_Empty  in  1.
- rx_fifo_Full  in  1.
- baud_div  out  DIV_W  baud divisor.
- uart_reset  out  1  UART core reset.

Behaviour:
- Register map (byte offsets):
  - 0x0 DATA: W pushes TX, R pops RX.
  - 0x4 STATUS: bit0 tx_full, bit1 rx_empty, bit2 rx_full, bit3 overrun (sticky, W1C); other bits RO/ignored.
  - 0x8 CTRL: bit0 soft reset, write-1, reads 0.
  - 0xC BAUD: RW, low DIV_W bits.
  - Other offsets unmapped.
- Reset: PRDATA=0, PREADY=0, PSLVERR=0, both FIFO strobes 0, overrun=0, uart_reset=0, FSM=IDLE.
  - baud_div resets to 1.
  - PRESET mid-transfer aborts without a strobe.
- FSM states: IDLE, ACCESS, STALL, RESP.
  - IDLE -> ACCESS on PSEL & !PENABLE.
  - ACCESS (first PENABLE cycle) evaluates the request:
    - If the resource is ready: strobe/register update at this edge -> RESP.
    - DATA write while tx_fifo_Full, DATA read while rx_fifo_Empty, or uart_reset active -> STALL.
  - STALL rechecks each cycle and counts cycles.
    - Resource becomes ready -> act -> RESP.
    - Count reaches TIMEOUT (when TIMEOUT != 0) -> RESP with PSLVERR=1, no strobe.
  - RESP: PREADY=1 for exactly one cycle -> IDLE.
  - Minimum transfer: setup + 2 access cycles (one wait state).
- Strobes:
  - tx_fifo_writeEn and rx_fifo_readEn are each high for exactly one cycle per successful DATA access, never both.
  - PRDATA captures {zero-extend, rx_fifo_dataOut} at the same edge readEn rises.
- Errors:
  - Unmapped address -> RESP with PSLVERR=1, no side effects.
  - Write to STATUS is not an error (W1C only).
- PSEL dropped while in ACCESS or STALL (protocol violation) -> IDLE, no strobe, no PREADY.
- overrun sets on any cycle with rx_fifo_Full=1.
  - Simultaneous set and W1C clear: set wins.
- Soft reset:
  - CTRL bit0=1 asserts uart_reset for exactly RST_HOLD cycles via down-counter.
  - Re-write during the hold restarts the count.
  - Also clears overrun; baud_div is retained.
- STALL counter and hold counter saturate; no wrap-around.

Optional Feature:
- UART_APB_IRQ_EN defined:
  - Adds output irq (1) and IER register at 0x10: bit0 rx_not_empty, bit1 tx_not_full, bit2 overrun; IER resets to 0.
  - irq is registered: OR of enabled conditions, one-cycle latency.
- Undefined: no irq port; 0x10 is unmapped (PSLVERR).

Decomposition:
- Package uart_apb_pkg holds:
  - Offset constants (DATA/STATUS/CTRL/BAUD/IER).
  - FSM state enum.
  - STATUS/IER bit-index constants.
- One sub-module, uart_apb_hold_timer: loadable saturating down-counter with a done flag.
  - Instantiated twice: STALL timeout and reset hold.

Test Plan:
- Write 0x5A to DATA, FIFO not full -> tx_fifo_writeEn single pulse with dataIn=0x5A; PREADY on 3rd cycle after setup; PSLVERR=0.
- Read DATA with rx_fifo_dataOut=0xC3, not empty -> PRDATA=0x000000C3 with PREADY; one readEn pulse.
- Read DATA with rx_fifo_Empty held, TIMEOUT=64 -> PREADY+PSLVERR after 64 stall cycles; no readEn.
- Same read, Empty drops at stall cycle 10 -> completes OK, PSLVERR=0.
- Write CTRL=1, RST_HOLD=16 -> uart_reset high exactly 16 cycles.
  - DATA write issued during the hold stalls, then completes.
- Access offset 0x14 -> PSLVERR=1, no strobes.
- rx_fifo_Full pulse -> STATUS reads 0x0C.
- Write STATUS 0x8 -> STATUS bit3 clears.
- PRESET asserted during STALL -> all outputs 0 next cycle; baud_div=1.
